// File: rtl/bus_xfer_pkg.sv
// Shared types and encodings for the bus transfer arbiter.
// Source codes, destination bit positions and the hold-counter range live here.
package bus_xfer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    LATCH = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam logic [1:0] SRC_A   = 2'b00;
  localparam logic [1:0] SRC_X   = 2'b01;
  localparam logic [1:0] SRC_IMM = 2'b10;
  localparam logic [1:0] SRC_ILL = 2'b11;

  localparam int DST_A = 3;
  localparam int DST_B = 2;
  localparam int DST_X = 1;
  localparam int DST_Q = 0;

  localparam int HOLD_MIN = 1;
  localparam int HOLD_MAX = 7;
  localparam int CNT_W    = 3;

  // A register never loads from itself; an illegal source loads nothing.
  function automatic logic [3:0] trig_mask(input logic [1:0] src, input logic [3:0] dst);
    logic [3:0] m;
    m = dst;
    case (src)
      SRC_A:   m[DST_A] = 1'b0;
      SRC_X:   m[DST_X] = 1'b0;
      SRC_ILL: m = 4'b0000;
      default: m = dst;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/bus_transfer_arbiter_if.sv
// Requester handshake plus bus drive/load strobes and status of the transfer arbiter.
// The master side is the pair of requesters and bus observers; the slave side is the arbiter.
interface bus_transfer_arbiter_if;

  logic       req0_valid;
  logic       req1_valid;
  logic [1:0] req0_src;
  logic [1:0] req1_src;
  logic [3:0] req0_dst;
  logic [3:0] req1_dst;
  logic [7:0] req0_imm;
  logic [7:0] req1_imm;
  logic       req0_ready;
  logic       req1_ready;

  logic       assertBarA;
  logic       assertBarX;
  logic       imm_oe;
  logic [7:0] imm_out;
  logic       triggerA;
  logic       triggerB;
  logic       triggerX;
  logic       triggerQ;

  logic       busy;
  logic       done;
  logic       done_id;
  logic       error;

  modport slave (
    input  req0_valid, req1_valid, req0_src, req1_src,
    input  req0_dst, req1_dst, req0_imm, req1_imm,
    output req0_ready, req1_ready,
    output assertBarA, assertBarX, imm_oe, imm_out,
    output triggerA, triggerB, triggerX, triggerQ,
    output busy, done, done_id, error
  );

  modport master (
    output req0_valid, req1_valid, req0_src, req1_src,
    output req0_dst, req1_dst, req0_imm, req1_imm,
    input  req0_ready, req1_ready,
    input  assertBarA, assertBarX, imm_oe, imm_out,
    input  triggerA, triggerB, triggerX, triggerQ,
    input  busy, done, done_id, error
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter with a last-grant register and one-hot grant.
// After reset last_grant is 1 so requester 0 wins the first contested cycle.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] valid,
  input  logic       enable,
  output logic [1:0] grant
);

  logic last_grant;

  always_comb begin
    grant = 2'b00;
    if (enable) begin
      if (valid == 2'b11) begin
        grant = last_grant ? 2'b01 : 2'b10;
      end else begin
        grant = valid;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (|grant) begin
      last_grant <= grant[1];
    end
  end

endmodule

// File: rtl/bus_transfer_arbiter.sv
// Arbitrates two transfer requesters onto a shared register bus and sequences
// the source drive enable, destination load strobes and completion status.
//
// state | meaning
// IDLE  | no transfer; ready offered to the arbitration winner
// DRIVE | source enable active, bus settling (error pulse here for src=11)
// LATCH | source still driving, destination triggers high for this cycle
// HOLD  | source keeps driving for HOLD_CYCLES; done on the last one
module bus_transfer_arbiter
  import bus_xfer_pkg::*;
#(
  parameter int HOLD_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  bus_transfer_arbiter_if.slave bus
);

  state_t             state, state_n;
  logic   [1:0]       grant;
  logic               accept;

  logic   [1:0]       src_q, src_n;
  logic   [3:0]       dst_q, dst_n;
  logic   [7:0]       imm_q, imm_n;
  logic               id_q, id_n;
  logic   [CNT_W-1:0] cnt_q, cnt_n;

  logic               bar_a_q, bar_a_n;
  logic               bar_x_q, bar_x_n;
  logic               imm_oe_q, imm_oe_n;
  logic   [7:0]       imm_out_q, imm_out_n;
  logic   [3:0]       trig_q, trig_n;
  logic               busy_q, busy_n;
  logic               done_q, done_n;
  logic               done_id_q, done_id_n;
  logic               err_q, err_n;

  logic               drive_on;
  logic   [1:0]       drive_sel;
  logic   [7:0]       drive_imm;
  logic   [1:0]       src_in;
  logic   [3:0]       dst_in;
  logic   [7:0]       imm_in;

  rr_arbiter2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .valid  ({bus.req1_valid, bus.req0_valid}),
    .enable ((state == IDLE) && !reset),
    .grant  (grant)
  );

  assign bus.req0_ready = grant[0];
  assign bus.req1_ready = grant[1];
  assign accept         = |grant;

  assign src_in = grant[1] ? bus.req1_src : bus.req0_src;
  assign dst_in = grant[1] ? bus.req1_dst : bus.req0_dst;
  assign imm_in = grant[1] ? bus.req1_imm : bus.req0_imm;

  // Every output is computed for the next state and registered, so enables
  // and strobes line up exactly with the state they belong to.
  always_comb begin
    state_n   = state;
    src_n     = src_q;
    dst_n     = dst_q;
    imm_n     = imm_q;
    id_n      = id_q;
    cnt_n     = cnt_q;
    bar_a_n   = 1'b1;
    bar_x_n   = 1'b1;
    imm_oe_n  = 1'b0;
    imm_out_n = 8'h00;
    trig_n    = 4'b0000;
    busy_n    = 1'b0;
    done_n    = 1'b0;
    done_id_n = done_id_q;
    err_n     = 1'b0;
    drive_on  = 1'b0;
    drive_sel = src_q;
    drive_imm = imm_q;

    case (state)
      IDLE: begin
        if (accept) begin
          state_n   = DRIVE;
          src_n     = src_in;
          dst_n     = dst_in;
          imm_n     = imm_in;
          id_n      = grant[1];
          busy_n    = 1'b1;
          err_n     = (src_in == SRC_ILL);
          drive_on  = 1'b1;
          drive_sel = src_in;
          drive_imm = imm_in;
        end
      end
      DRIVE: begin
        if (src_q == SRC_ILL) begin
          state_n = IDLE;
        end else begin
          state_n  = LATCH;
          busy_n   = 1'b1;
          drive_on = 1'b1;
          trig_n   = trig_mask(src_q, dst_q);
        end
      end
      LATCH: begin
        state_n  = HOLD;
        busy_n   = 1'b1;
        drive_on = 1'b1;
        cnt_n    = CNT_W'(HOLD_CYCLES - 1);
        done_n   = (HOLD_CYCLES == 1);
        if (HOLD_CYCLES == 1) done_id_n = id_q;
      end
      HOLD: begin
        if (cnt_q == '0) begin
          state_n = IDLE;
        end else begin
          busy_n   = 1'b1;
          drive_on = 1'b1;
          cnt_n    = cnt_q - 1'b1;
          done_n   = (cnt_q == CNT_W'(1));
          if (cnt_q == CNT_W'(1)) done_id_n = id_q;
        end
      end
      default: state_n = IDLE;
    endcase

    if (drive_on) begin
      case (drive_sel)
        SRC_A:   bar_a_n = 1'b0;
        SRC_X:   bar_x_n = 1'b0;
        SRC_IMM: begin
          imm_oe_n  = 1'b1;
          imm_out_n = drive_imm;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      src_q     <= SRC_A;
      dst_q     <= 4'b0000;
      imm_q     <= 8'h00;
      id_q      <= 1'b0;
      cnt_q     <= '0;
      bar_a_q   <= 1'b1;
      bar_x_q   <= 1'b1;
      imm_oe_q  <= 1'b0;
      imm_out_q <= 8'h00;
      trig_q    <= 4'b0000;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state     <= state_n;
      src_q     <= src_n;
      dst_q     <= dst_n;
      imm_q     <= imm_n;
      id_q      <= id_n;
      cnt_q     <= cnt_n;
      bar_a_q   <= bar_a_n;
      bar_x_q   <= bar_x_n;
      imm_oe_q  <= imm_oe_n;
      imm_out_q <= imm_out_n;
      trig_q    <= trig_n;
      busy_q    <= busy_n;
      done_q    <= done_n;
      done_id_q <= done_id_n;
      err_q     <= err_n;
    end
  end

  assign bus.assertBarA = bar_a_q;
  assign bus.assertBarX = bar_x_q;
  assign bus.imm_oe     = imm_oe_q;
  assign bus.imm_out    = imm_out_q;
  assign bus.triggerA   = trig_q[DST_A];
  assign bus.triggerB   = trig_q[DST_B];
  assign bus.triggerX   = trig_q[DST_X];
  assign bus.triggerQ   = trig_q[DST_Q];
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.done_id    = done_id_q;
  assign bus.error      = err_q;

endmodule

// File: tb/tb_bus_transfer_arbiter.sv
// Directed bench for bus_transfer_arbiter with HOLD_CYCLES=2.
// Cycle k after acceptance: k=1 DRIVE, k=2 LATCH, k=3..2+HOLD HOLD, k=3+HOLD IDLE.
module tb_bus_transfer_arbiter;
  import bus_xfer_pkg::*;

  localparam int HOLD = 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  bus_transfer_arbiter_if bus ();

  bus_transfer_arbiter #(.HOLD_CYCLES(HOLD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Bus driver exclusivity and quiet bus whenever the arbiter is idle.
  always @(negedge clk) begin
    if (mon_en) begin
      int act;
      act = int'(!bus.assertBarA) + int'(!bus.assertBarX) + int'(bus.imm_oe);
      checks++;
      if (act > 1 || (!bus.busy && act != 0)) begin
        errors++;
        $display("FAIL bus_drivers t=%0t active=%0d busy=%0b want <=1 and 0 when idle", $time, act, bus.busy);
      end
    end
  end

  task automatic set_req(input int id, input bit v, input logic [1:0] s,
                         input logic [3:0] d, input logic [7:0] i);
    if (id == 0) begin
      bus.req0_valid = v; bus.req0_src = s; bus.req0_dst = d; bus.req0_imm = i;
    end else begin
      bus.req1_valid = v; bus.req1_src = s; bus.req1_dst = d; bus.req1_imm = i;
    end
  endtask

  // Presents one request in an idle cycle, then scrambles the fields after acceptance.
  task automatic issue(input int id, input logic [1:0] s, input logic [3:0] d,
                       input logic [7:0] i, output bit acc);
    @(negedge clk);
    set_req(id, 1'b1, s, d, i);
    #1;
    acc = (id == 0) ? bus.req0_ready : bus.req1_ready;
    @(posedge clk);
    #1;
    set_req(id, 1'b0, ~s, ~d, ~i);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (bus.busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.busy) begin
      errors++;
      $display("FAIL idle_timeout busy=%0b after %0d cycles want 0", bus.busy, n);
    end
  endtask

  task automatic test_reset();
    set_req(0, 1'b1, SRC_A, 4'b0100, 8'h00);
    set_req(1, 1'b1, SRC_X, 4'b1000, 8'h00);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.assertBarA, bus.assertBarX, bus.imm_oe} !== 3'b110) begin
      errors++;
      $display("FAIL reset_enables got %b want 110", {bus.assertBarA, bus.assertBarX, bus.imm_oe});
    end
    checks++;
    if (bus.imm_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_imm_out got %h want 00", bus.imm_out);
    end
    checks++;
    if ({bus.triggerA, bus.triggerB, bus.triggerX, bus.triggerQ} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_triggers got %b want 0000",
               {bus.triggerA, bus.triggerB, bus.triggerX, bus.triggerQ});
    end
    checks++;
    if ({bus.busy, bus.done, bus.done_id, bus.error} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_status got %b want 0000", {bus.busy, bus.done, bus.done_id, bus.error});
    end
    checks++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin
      errors++;
      $display("FAIL reset_ready got %b want 00", {bus.req0_ready, bus.req1_ready});
    end
    set_req(0, 1'b0, SRC_A, 4'b0000, 8'h00);
    set_req(1, 1'b0, SRC_A, 4'b0000, 8'h00);
    mon_en = 1'b1;
    reset  = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    int grants[$];
    int gcyc[$];
    int want;
    @(negedge clk);
    set_req(0, 1'b1, SRC_X, 4'b0000, 8'h00);
    set_req(1, 1'b1, SRC_X, 4'b0000, 8'h00);
    for (int c = 0; c < 30; c++) begin
      #1;
      checks++;
      if (bus.req0_ready && bus.req1_ready) begin
        errors++;
        $display("FAIL rr_both_ready cycle=%0d got 11 want at most one", c);
      end
      if (bus.req0_ready) begin grants.push_back(0); gcyc.push_back(c); end
      else if (bus.req1_ready) begin grants.push_back(1); gcyc.push_back(c); end
      @(negedge clk);
    end
    set_req(0, 1'b0, SRC_A, 4'b0000, 8'h00);
    set_req(1, 1'b0, SRC_A, 4'b0000, 8'h00);
    checks++;
    if (grants.size() < 4) begin
      errors++;
      $display("FAIL rr_grant_count got %0d want >=4", grants.size());
    end else begin
      for (int g = 0; g < 4; g++) begin
        want = g % 2;
        checks++;
        if (grants[g] != want) begin
          errors++;
          $display("FAIL rr_order idx=%0d got %0d want %0d", g, grants[g], want);
        end
      end
      for (int g = 0; g < 3; g++) begin
        checks++;
        if (gcyc[g+1] - gcyc[g] != 3 + HOLD) begin
          errors++;
          $display("FAIL rr_back_to_back idx=%0d gap %0d want %0d", g, gcyc[g+1] - gcyc[g], 3 + HOLD);
        end
      end
    end
    wait_idle();
  endtask

  task automatic test_src_a();
    bit   acc;
    int   nbar, ntrb, trb_k, noth, ndone, done_k;
    logic did, busy1, busy_end;
    nbar = 0; ntrb = 0; trb_k = 0; noth = 0; ndone = 0; done_k = 0;
    did = 1'bx; busy1 = 1'bx; busy_end = 1'bx;
    issue(0, SRC_A, 4'b0100, 8'h00, acc);
    for (int k = 1; k <= 3 + HOLD; k++) begin
      @(negedge clk);
      if (!bus.assertBarA) nbar++;
      if (bus.triggerB) begin ntrb++; trb_k = k; end
      if (bus.triggerA || bus.triggerX || bus.triggerQ) noth++;
      if (bus.done) begin ndone++; done_k = k; did = bus.done_id; end
      if (k == 1) busy1 = bus.busy;
      if (k == 3 + HOLD) busy_end = bus.busy;
    end
    checks++;
    if (acc !== 1'b1) begin errors++; $display("FAIL srca_accept got %0b want 1", acc); end
    checks++;
    if (nbar != 2 + HOLD) begin errors++; $display("FAIL srca_bar_cycles got %0d want %0d", nbar, 2 + HOLD); end
    checks++;
    if (ntrb != 1 || trb_k != 2) begin
      errors++; $display("FAIL srca_triggerB count=%0d at k=%0d want 1 at k=2", ntrb, trb_k);
    end
    checks++;
    if (noth != 0) begin errors++; $display("FAIL srca_other_triggers got %0d want 0", noth); end
    checks++;
    if (ndone != 1 || done_k != 2 + HOLD || did !== 1'b0) begin
      errors++;
      $display("FAIL srca_done count=%0d k=%0d id=%0b want 1 k=%0d id=0", ndone, done_k, did, 2 + HOLD);
    end
    checks++;
    if (busy1 !== 1'b1 || busy_end !== 1'b0) begin
      errors++; $display("FAIL srca_busy drive=%0b end=%0b want 1 0", busy1, busy_end);
    end
    wait_idle();
  endtask

  task automatic test_imm();
    bit         acc;
    int         noe, nbad, nother, ndone;
    logic [3:0] trig2;
    logic       did;
    noe = 0; nbad = 0; nother = 0; ndone = 0; trig2 = 4'hx; did = 1'bx;
    issue(1, SRC_IMM, 4'b1011, 8'hA5, acc);
    for (int k = 1; k <= 3 + HOLD; k++) begin
      @(negedge clk);
      if (bus.imm_oe) begin
        noe++;
        if (bus.imm_out !== 8'hA5) nbad++;
      end
      if (!bus.assertBarA || !bus.assertBarX) nbad++;
      if (k == 2) trig2 = {bus.triggerA, bus.triggerB, bus.triggerX, bus.triggerQ};
      else if (bus.triggerA || bus.triggerB || bus.triggerX || bus.triggerQ) nother++;
      if (bus.done) begin ndone++; did = bus.done_id; end
    end
    checks++;
    if (acc !== 1'b1) begin errors++; $display("FAIL imm_accept got %0b want 1", acc); end
    checks++;
    if (noe != 2 + HOLD || nbad != 0) begin
      errors++; $display("FAIL imm_drive oe_cycles=%0d bad=%0d want %0d 0", noe, nbad, 2 + HOLD);
    end
    checks++;
    if (trig2 !== 4'b1011 || nother != 0) begin
      errors++; $display("FAIL imm_triggers latch=%b others=%0d want 1011 0", trig2, nother);
    end
    checks++;
    if (ndone != 1 || did !== 1'b1) begin
      errors++; $display("FAIL imm_done count=%0d id=%0b want 1 1", ndone, did);
    end
    wait_idle();
  endtask

  task automatic test_mask();
    bit         acc;
    int         ntrig, ndone, nbarx;
    logic [3:0] trig2;
    ntrig = 0; ndone = 0; nbarx = 0; trig2 = 4'hx;
    issue(0, SRC_X, 4'b0010, 8'h00, acc);
    for (int k = 1; k <= 3 + HOLD; k++) begin
      @(negedge clk);
      if (bus.triggerA || bus.triggerB || bus.triggerX || bus.triggerQ) ntrig++;
      if (bus.done) ndone++;
      if (!bus.assertBarX) nbarx++;
    end
    checks++;
    if (ntrig != 0 || ndone != 1 || nbarx != 2 + HOLD) begin
      errors++;
      $display("FAIL mask_x trig=%0d done=%0d barx=%0d want 0 1 %0d", ntrig, ndone, nbarx, 2 + HOLD);
    end
    wait_idle();
    issue(0, SRC_A, 4'b1001, 8'h00, acc);
    for (int k = 1; k <= 3 + HOLD; k++) begin
      @(negedge clk);
      if (k == 2) trig2 = {bus.triggerA, bus.triggerB, bus.triggerX, bus.triggerQ};
    end
    checks++;
    if (trig2 !== 4'b0001) begin
      errors++; $display("FAIL mask_a latch_triggers got %b want 0001", trig2);
    end
    wait_idle();
  endtask

  task automatic test_illegal();
    bit   acc;
    int   nerr, err_k, ndrv, ntrig, ndone;
    logic busy2;
    nerr = 0; err_k = 0; ndrv = 0; ntrig = 0; ndone = 0; busy2 = 1'bx;
    issue(1, SRC_ILL, 4'b1111, 8'h3C, acc);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (bus.error) begin nerr++; err_k = k; end
      if (!bus.assertBarA || !bus.assertBarX || bus.imm_oe) ndrv++;
      if (bus.triggerA || bus.triggerB || bus.triggerX || bus.triggerQ) ntrig++;
      if (bus.done) ndone++;
      if (k == 2) busy2 = bus.busy;
    end
    checks++;
    if (nerr != 1 || err_k != 1) begin
      errors++; $display("FAIL illegal_error count=%0d k=%0d want 1 k=1", nerr, err_k);
    end
    checks++;
    if (ndrv != 0 || ntrig != 0 || ndone != 0) begin
      errors++; $display("FAIL illegal_quiet drv=%0d trig=%0d done=%0d want 0 0 0", ndrv, ntrig, ndone);
    end
    checks++;
    if (busy2 !== 1'b0) begin errors++; $display("FAIL illegal_return busy=%0b want 0", busy2); end
    wait_idle();
  endtask

  task automatic test_reset_mid();
    bit acc;
    int ndone;
    ndone = 0;
    issue(0, SRC_A, 4'b0100, 8'h00, acc);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.triggerB !== 1'b1) begin errors++; $display("FAIL rstmid_in_latch triggerB=%0b want 1", bus.triggerB); end
    reset = 1'b1;
    set_req(0, 1'b1, SRC_A, 4'b0100, 8'h00);
    @(negedge clk);
    if (bus.done) ndone++;
    checks++;
    if ({bus.assertBarA, bus.assertBarX, bus.imm_oe, bus.busy} !== 4'b1100) begin
      errors++;
      $display("FAIL rstmid_release barA/barX/oe/busy got %b want 1100",
               {bus.assertBarA, bus.assertBarX, bus.imm_oe, bus.busy});
    end
    checks++;
    if ({bus.triggerA, bus.triggerB, bus.triggerX, bus.triggerQ} !== 4'b0000) begin
      errors++;
      $display("FAIL rstmid_triggers got %b want 0000",
               {bus.triggerA, bus.triggerB, bus.triggerX, bus.triggerQ});
    end
    checks++;
    if (bus.req0_ready !== 1'b0) begin errors++; $display("FAIL rstmid_ready got %0b want 0", bus.req0_ready); end
    @(negedge clk);
    if (bus.done) ndone++;
    set_req(0, 1'b0, SRC_A, 4'b0000, 8'h00);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    checks++;
    if (ndone != 0) begin errors++; $display("FAIL rstmid_no_done got %0d want 0", ndone); end
  endtask

  initial begin
    set_req(0, 1'b0, SRC_A, 4'b0000, 8'h00);
    set_req(1, 1'b0, SRC_A, 4'b0000, 8'h00);
    test_reset();
    test_round_robin();
    test_src_a();
    test_imm();
    test_mask();
    test_illegal();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_transfer_arbiter.md
BUS_TRANSFER_ARBITER -- requirements
Module: bus_transfer_arbiter

Interface
REQ-001 Parameter: HOLD_CYCLES, 1, cycles the source keeps driving dbus after the trigger pulse (legal range 1..7).
REQ-002 Ports: clk  in  1  single clock, all state updates on rising edge.
REQ-003 Ports: reset  in  1  synchronous, active-high reset.
REQ-004 Ports: req0_valid, req1_valid  in  1 each  transfer request from requester 0 (fetch) and requester 1 (execute).
REQ-005 Ports: req0_src, req1_src  in  2 each  source: 00=A, 01=X, 10=IMM, 11=illegal.
REQ-006 Ports: req0_dst, req1_dst  in  4 each  destination mask {A,B,X,Q}, bit3=A.
REQ-007 Ports: req0_imm, req1_imm  in  8 each  immediate byte, used when src=IMM.
REQ-008 Ports: req0_ready, req1_ready  out  1 each  acceptance strobe.
REQ-009 Ports: assertBarA, assertBarX  out  1 each  active-low bus drive enables for registers A and X.
REQ-010 Ports: imm_oe  out  1; imm_out  out  8  immediate bus driver enable and value.
REQ-011 Ports: triggerA, triggerB, triggerX, triggerQ  out  1 each  register load strobes.
REQ-012 Ports: busy  out  1; done  out  1; done_id  out  1; error  out  1  status.

Function
REQ-013 States SHALL be IDLE, DRIVE, LATCH, HOLD; IDLE->DRIVE on acceptance, DRIVE->LATCH, LATCH->HOLD, HOLD->IDLE after HOLD_CYCLES cycles.
REQ-014 reqN_ready SHALL be high only in IDLE, for at most one requester per cycle; a request is accepted when valid and ready are high in the same cycle.
REQ-015 Arbitration SHALL be round-robin: with both valid, the requester not granted last wins; a sole valid requester wins immediately.
REQ-016 src, dst and imm SHALL be captured on acceptance; later input changes SHALL not affect the transfer in flight.
REQ-017 The selected source enable (assertBarA/assertBarX low, or imm_oe high with imm_out=captured imm) SHALL be active throughout DRIVE, LATCH and HOLD and inactive in IDLE.
REQ-018 Triggers for the captured dst bits SHALL be high for exactly the one LATCH cycle; all triggers SHALL be low in every other state.
REQ-019 The dst bit equal to the source register SHALL be masked (A->A and X->X produce no trigger).
REQ-020 dst=0000 SHALL complete normally with no trigger.
REQ-021 src=11 SHALL pulse error for one cycle in the cycle after acceptance, drive nothing, fire no trigger, and return to IDLE without done.
REQ-022 At most one of {assertBarA low, assertBarX low, imm_oe} SHALL be active in any cycle.
REQ-023 Latency: acceptance at edge t -> DRIVE at t+1, LATCH at t+2, IDLE at t+3+HOLD_CYCLES; done SHALL pulse one cycle on the last HOLD cycle, with done_id=granted requester.
REQ-024 busy SHALL be high in every non-IDLE state.
REQ-025 Back-to-back requests SHALL incur no gap beyond the single IDLE cycle.
REQ-026 All outputs except reqN_ready SHALL be registered.

Reset
REQ-027 On reset: state=IDLE, assertBarA=assertBarX=1, imm_oe=0, imm_out=0, all triggers=0, busy=done=done_id=error=0, last-grant=1 (requester 0 favoured next).
REQ-028 Reset mid-transfer SHALL abort it without done or trigger; enables SHALL release on that same edge.
REQ-029 reqN_ready SHALL be low while reset is high.

Structure
REQ-030 Package bus_xfer_pkg SHALL hold the state enum, source encodings, dst bit positions and HOLD_CYCLES range limit.
REQ-031 Arbitration SHALL be a sub-module rr_arbiter2 (two valids, last-grant register, one-hot grant).

Verification
REQ-032 req0 src=A dst=0100 -> assertBarA low for 2+HOLD_CYCLES cycles, triggerB high exactly one cycle at t+2, done_id=0.
REQ-033 req0 and req1 both valid continuously -> grants alternate 0,1,0,1 after reset; no cycle with both readies high.
REQ-034 src=IMM imm=8'hA5 dst=1011 -> imm_oe high, imm_out=A5, triggerA/X/Q high together one cycle, triggerB low.
REQ-035 src=X dst=0010 -> no trigger, done pulses; src=11 -> error pulse, no enables, no done.
REQ-036 reset asserted during LATCH -> next cycle all enables inactive, triggers low, busy low, no done.
REQ-037 Every cycle: assert at most one bus driver active and no driver active in IDLE.
